// File: rtl/thor_pkg.sv
// Shared types and helpers for the fetch/decode front end.
// Instruction words are stored without the fixed 2'b11 low bits.
package thor_pkg;

    localparam int INSTR_W = 30;
    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] instr_expand(
        input logic [INSTR_W-1:0] w
    );
        return {w, 2'b11};
    endfunction

endpackage

// File: rtl/instr_fetch_queue_regfile.sv
// Storage array for the fetch queue.
// One synchronous write port, one asynchronous read port, no reset.
module fifo_regfile #(
    parameter int DEPTH = 8,
    parameter int IWIDTH = 30,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clockGate,
    input  logic              wrEn,
    input  logic [AW-1:0]     wrAddr,
    input  logic [IWIDTH-1:0] wrData,
    input  logic [AW-1:0]     rdAddr,
    output logic [IWIDTH-1:0] rdData
);

    logic [IWIDTH-1:0] mem [DEPTH];

    // Write the incoming word; contents survive reset and flush.
    always_ff @(posedge clockGate) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction buffer between fetch and decode.
// Pointers carry a wrap bit; all outputs decode registered state only.
module instr_fetch_queue
    import thor_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IWIDTH = INSTR_W,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clockGate,
    input  logic              resetn,
    input  logic              push,
    input  logic [IWIDTH-1:0] instr,
    output logic              queueFull,
    input  logic              flush,
    output logic              popValid,
    input  logic              popReady,
    output logic [31:0]       popInstr,
    output logic [CNT_W-1:0]  count
);

    logic [CNT_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  rdPtr;
    logic [IWIDTH-1:0] headWord;
    logic              wr;
    logic              rd;

    assign queueFull = (count == CNT_W'(DEPTH));
    assign popValid  = (count != '0);

    assign wr = push & ~queueFull & ~flush;
    assign rd = popReady & popValid & ~flush;

    // Flush wins over everything; otherwise pointers and count track wr/rd.
    always_ff @(posedge clockGate or negedge resetn) begin
        if (!resetn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wrPtr <= wrPtr + CNT_W'(1);
            end
            if (rd) begin
                rdPtr <= rdPtr + CNT_W'(1);
            end
            if (wr && !rd) begin
                count <= count + CNT_W'(1);
            end else if (rd && !wr) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    fifo_regfile #(
        .DEPTH  (DEPTH),
        .IWIDTH (IWIDTH)
    ) uRegfile (
        .clockGate (clockGate),
        .wrEn      (wr),
        .wrAddr    (wrPtr[CNT_W-2:0]),
        .wrData    (instr),
        .rdAddr    (rdPtr[CNT_W-2:0]),
        .rdData    (headWord)
    );

    assign popInstr = instr_expand(headWord);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue.
// Vector table for fill/drain/latency, hand sequences for wrap, flush, reset.
module tb_instr_fetch_queue;

    logic        clockGate = 1'b0;
    logic        resetn;
    logic        push;
    logic [29:0] instr;
    logic        queueFull;
    logic        flush;
    logic        popValid;
    logic        popReady;
    logic [31:0] popInstr;
    logic [3:0]  count;

    int nApplied = 0;
    int nMiss = 0;

    typedef struct {
        logic        push;
        logic [29:0] instr;
        logic        popReady;
        logic        flush;
        logic        expValid;
        logic        expFull;
        logic [3:0]  expCount;
        logic        chkInstr;
        logic [29:0] expWord;
    } vec_t;

    vec_t vq[$];

    instr_fetch_queue #(.DEPTH(8)) dut (
        .clockGate (clockGate),
        .resetn    (resetn),
        .push      (push),
        .instr     (instr),
        .queueFull (queueFull),
        .flush     (flush),
        .popValid  (popValid),
        .popReady  (popReady),
        .popInstr  (popInstr),
        .count     (count)
    );

    always #5 clockGate = ~clockGate;

    function automatic logic [31:0] expand(input logic [29:0] w);
        return {w, 2'b11};
    endfunction

    function automatic vec_t mk(
        input logic p, input logic [29:0] w, input logic pr,
        input logic fl, input logic ev, input logic ef,
        input logic [3:0] ec, input logic ck, input logic [29:0] ew
    );
        vec_t v;
        v.push = p; v.instr = w; v.popReady = pr; v.flush = fl;
        v.expValid = ev; v.expFull = ef; v.expCount = ec;
        v.chkInstr = ck; v.expWord = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic ev,
                              input logic ef, input logic [3:0] ec);
        check({tag, ".count"}, 32'(count), 32'(ec));
        check({tag, ".popValid"}, 32'(popValid), 32'(ev));
        check({tag, ".queueFull"}, 32'(queueFull), 32'(ef));
    endtask

    task automatic tick();
        @(posedge clockGate);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; popReady = 1'b0; flush = 1'b0; instr = '0;
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        repeat (2) @(posedge clockGate);
        #1;
        resetn = 1'b1;
        checkState("reset", 1'b0, 1'b0, 4'd0);

        // fill with 1..8, 9th push ignored, then drain in order
        for (int i = 1; i <= 8; i++) begin
            vq.push_back(mk(1'b1, 30'(i), 1'b0, 1'b0,
                            i > 1, 1'b0, 4'(i - 1), i > 1, 30'd1));
        end
        vq.push_back(mk(1'b1, 30'd9, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 1'b1, 30'd1));
        for (int i = 1; i <= 8; i++) begin
            vq.push_back(mk(1'b0, 30'd0, 1'b1, 1'b0,
                            1'b1, i == 1, 4'(9 - i), 1'b1, 30'(i)));
        end
        // empty: push with popReady, no fall-through
        vq.push_back(mk(1'b1, 30'hA, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 30'd0));
        vq.push_back(mk(1'b0, 30'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 30'hA));
        vq.push_back(mk(1'b0, 30'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 30'hA));
        vq.push_back(mk(1'b0, 30'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 30'd0));
        vq.push_back(mk(1'b0, 30'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 30'd0));

        foreach (vq[k]) begin
            push = vq[k].push;
            instr = vq[k].instr;
            popReady = vq[k].popReady;
            flush = vq[k].flush;
            checkState($sformatf("vec%0d", k), vq[k].expValid,
                       vq[k].expFull, vq[k].expCount);
            if (vq[k].chkInstr) begin
                check($sformatf("vec%0d.popInstr", k), popInstr,
                      expand(vq[k].expWord));
            end
            tick();
        end
        idle();

        // steady push+pop at count 3 across several wraps
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; instr = 30'h100 + 30'(i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            push = 1'b1; popReady = 1'b1; instr = 30'h103 + 30'(i);
            check($sformatf("wrap%0d.count", i), 32'(count), 32'd3);
            check($sformatf("wrap%0d.popInstr", i), popInstr,
                  expand(30'h100 + 30'(i)));
            tick();
        end
        push = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wrapDrain%0d", i), popInstr,
                  expand(30'h114 + 30'(i)));
            tick();
        end
        idle();
        checkState("wrapEnd", 1'b0, 1'b0, 4'd0);

        // flush with simultaneous push and pop
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; instr = 30'h200 + 30'(i);
            tick();
        end
        push = 1'b1; instr = 30'h2FF; popReady = 1'b1; flush = 1'b1;
        checkState("flushPre", 1'b1, 1'b0, 4'd5);
        tick();
        idle();
        checkState("flushPost", 1'b0, 1'b0, 4'd0);
        push = 1'b1; instr = 30'h077;
        tick();
        idle();
        checkState("flushRefill", 1'b1, 1'b0, 4'd1);
        check("flushRefill.popInstr", popInstr, expand(30'h077));
        popReady = 1'b1;
        tick();
        idle();
        checkState("flushDrain", 1'b0, 1'b0, 4'd0);

        // asynchronous reset between edges
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; instr = 30'h300 + 30'(i);
            tick();
        end
        idle();
        checkState("rstPre", 1'b1, 1'b0, 4'd4);
        #2 resetn = 1'b0;
        #1;
        checkState("rstLow", 1'b0, 1'b0, 4'd0);
        #1 resetn = 1'b1;
        push = 1'b1; instr = 30'h055;
        tick();
        idle();
        checkState("rstRefill", 1'b1, 1'b0, 4'd1);
        check("rstRefill.popInstr", popInstr, expand(30'h055));

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule
